// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and register typedefs for the register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Number of address bits needed to select one of n registers (at least 1).
  function automatic int addr_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          reg_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register select, x0 forcing, writeback bypass
// and the hazard flag seen by decode.
module rf_read_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]                rs,
  input  logic [NREGS-1:0][XLEN-1:0]   rf,
  input  logic [NREGS-1:0]             busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_rd,
  input  logic [XLEN-1:0]              wr_data,
  input  logic                         iss_en,
  input  logic [AW-1:0]                iss_rd,
  output logic [XLEN-1:0]              rv,
  output logic                         rbusy
);

  logic rs_zero;
  logic wr_match;
  logic iss_match;

  // Operand select with bypass; a retiring write hides the hazard unless the
  // same register is being reissued in this cycle.
  always_comb begin
    rs_zero   = (rs == '0);
    wr_match  = wr_en && (wr_rd == rs);
    iss_match = iss_en && (iss_rd == rs);
    rv        = '0;
    rbusy     = 1'b0;
    if (!rs_zero) begin
      rv    = wr_match ? wr_data : rf[rs];
      rbusy = busy[rs] && !(wr_match && !iss_match);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD bypassed read ports, one write port, a per-register
// busy scoreboard, a running busy count and a registered debug tap.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              NREGS     = NREGS_DEF,
  parameter int              NREAD     = 2,
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter int              AW        = addr_w(NREGS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREAD*AW-1:0]     rs,
  output logic [NREAD*XLEN-1:0]   rv,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_rd,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_rd,
  input  logic [XLEN-1:0]         wr_data,
  input  logic [AW-1:0]           dbg_sel,
  output logic [XLEN-1:0]         dbg_val,
  output logic [AW:0]             busy_cnt
);

  logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [AW:0]                busy_cnt_q, busy_cnt_d;
  logic [XLEN-1:0]            dbg_val_q, dbg_val_d;
  logic                       wr_hit;
  logic                       iss_hit;

  // Next state: write and retire first, then issue so a same-register issue
  // wins; the count moves only on real 0->1 / 1->0 busy transitions.
  always_comb begin
    wr_hit     = wr_en && (wr_rd != '0);
    iss_hit    = iss_en && (iss_rd != '0);
    rf_d       = rf_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (wr_hit) begin
      rf_d[wr_rd]   = wr_data;
      busy_d[wr_rd] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (iss_hit && !busy_q[iss_rd]) begin
      busy_cnt_d = busy_cnt_d + (AW+1)'(1);
    end
    if (wr_hit && busy_q[wr_rd] && !(iss_hit && (iss_rd == wr_rd))) begin
      busy_cnt_d = busy_cnt_d - (AW+1)'(1);
    end
    rf_d[0]   = '0;
    busy_d[0] = 1'b0;
    dbg_val_d = rf_d[dbg_sel];
  end

  // State registers; reset overrides any same-cycle write or issue.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= (i == 0) ? '0 : RESET_VAL;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
      dbg_val_q  <= '0;
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      dbg_val_q  <= dbg_val_d;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_port (
      .rs      (rs[k*AW +: AW]),
      .rf      (rf_q),
      .busy    (busy_q),
      .wr_en   (wr_en),
      .wr_rd   (wr_rd),
      .wr_data (wr_data),
      .iss_en  (iss_en),
      .iss_rd  (iss_rd),
      .rv      (rv[k*XLEN +: XLEN]),
      .rbusy   (rbusy[k])
    );
  end

  assign busy_cnt = busy_cnt_q;
  assign dbg_val  = dbg_val_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios plus random traffic, all checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NREAD = 3;
  localparam int AW    = $clog2(NREGS);
  localparam logic [XLEN-1:0] RV = 32'd2;

  logic                   clk;
  logic                   rstn;
  logic [NREAD*AW-1:0]    rs;
  logic [NREAD*XLEN-1:0]  rv;
  logic [NREAD-1:0]       rbusy;
  logic                   iss_en;
  logic [AW-1:0]          iss_rd;
  logic                   wr_en;
  logic [AW-1:0]          wr_rd;
  logic [XLEN-1:0]        wr_data;
  logic [AW-1:0]          dbg_sel;
  logic [XLEN-1:0]        dbg_val;
  logic [AW:0]            busy_cnt;

  regfile_sb #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .NREAD     (NREAD),
    .RESET_VAL (RV)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rs       (rs),
    .rv       (rv),
    .rbusy    (rbusy),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr_en    (wr_en),
    .wr_rd    (wr_rd),
    .wr_data  (wr_data),
    .dbg_sel  (dbg_sel),
    .dbg_val  (dbg_val),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [XLEN-1:0] m_rf [NREGS];
  bit              m_busy [NREGS];
  logic [XLEN-1:0] m_dbg;

  int  n_total = 0;
  int  n_bad   = 0;
  bit  chk_on  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rv_of(input int k);
    return rv[k*XLEN +: XLEN];
  endfunction

  function automatic int rs_of(input int k);
    return int'(rs[k*AW +: AW]);
  endfunction

  task automatic set_rs(input int k, input int a);
    rs[k*AW +: AW] = AW'(a);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  task automatic settle();
    #1;
  endtask

  // One clock cycle with the inputs currently driven: check the combinational
  // read side mid-cycle, advance the model at the edge, then check the
  // registered outputs just after it.
  task automatic cyc();
    int a;
    logic [XLEN-1:0] exp_rv;
    bit exp_rb;
    bit wm, im;
    #2;
    if (chk_on) begin
      for (int k = 0; k < NREAD; k++) begin
        a  = rs_of(k);
        wm = wr_en && (int'(wr_rd) == a);
        im = iss_en && (int'(iss_rd) == a);
        if (a == 0) exp_rv = '0;
        else if (wm) exp_rv = wr_data;
        else exp_rv = m_rf[a];
        exp_rb = (a != 0) && m_busy[a] && !(wm && !im);
        check($sformatf("rv%0d", k), 64'(rv_of(k)), 64'(exp_rv));
        check($sformatf("rbusy%0d", k), 64'(rbusy[k]), 64'(exp_rb));
      end
    end
    @(posedge clk);
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) begin
        m_rf[i]   = (i == 0) ? '0 : RV;
        m_busy[i] = 1'b0;
      end
      m_dbg = '0;
    end else begin
      if (wr_en && wr_rd != '0) begin
        m_rf[wr_rd]   = wr_data;
        m_busy[wr_rd] = 1'b0;
      end
      if (iss_en && iss_rd != '0) m_busy[iss_rd] = 1'b1;
      m_dbg = m_rf[dbg_sel];
    end
    #1;
    if (chk_on) begin
      check("busy_cnt", 64'(busy_cnt), 64'(m_count()));
      check("dbg_val", 64'(dbg_val), 64'(m_dbg));
    end
  endtask

  task automatic idle();
    iss_en = 1'b0; iss_rd = '0; wr_en = 1'b0; wr_rd = '0; wr_data = '0;
  endtask

  initial begin
    rstn = 1'b0; rs = '0; dbg_sel = '0;
    idle();
    for (int i = 0; i < NREGS; i++) begin
      m_rf[i] = 'x; m_busy[i] = 1'b0;
    end
    m_dbg = 'x;

    // Reset
    cyc();
    chk_on = 1'b1;
    check("rst_cnt", 64'(busy_cnt), 64'd0);
    check("rst_dbg", 64'(dbg_val), 64'd0);
    rstn = 1'b1;
    set_rs(0, 0); set_rs(1, 1); set_rs(2, 15);
    settle();
    check("rst_rv0", 64'(rv_of(0)), 64'd0);
    check("rst_rv1", 64'(rv_of(1)), 64'(RV));
    check("rst_rv2", 64'(rv_of(2)), 64'(RV));
    check("rst_rb", 64'(rbusy), 64'd0);
    cyc();

    // Write with same-cycle bypass, then through the array
    set_rs(0, 5);
    wr_en = 1'b1; wr_rd = AW'(5); wr_data = 32'hDEADBEEF;
    settle();
    check("byp_rv0", 64'(rv_of(0)), 64'hDEADBEEF);
    cyc();
    idle();
    settle();
    check("rf_rv0", 64'(rv_of(0)), 64'hDEADBEEF);
    cyc();

    // Write to x0 is dropped
    set_rs(0, 0); dbg_sel = '0;
    wr_en = 1'b1; wr_rd = '0; wr_data = 32'h1234;
    settle();
    check("x0_byp", 64'(rv_of(0)), 64'd0);
    cyc();
    idle();
    cyc();
    check("x0_dbg", 64'(dbg_val), 64'd0);

    // Scoreboard: issue at edge 1, retire in cycle 4
    set_rs(1, 7);
    iss_en = 1'b1; iss_rd = AW'(7);
    cyc();
    idle();
    settle();
    check("sb_c2_rb", 64'(rbusy[1]), 64'd1);
    check("sb_c2_cnt", 64'(busy_cnt), 64'd1);
    cyc();
    settle();
    check("sb_c3_rb", 64'(rbusy[1]), 64'd1);
    cyc();
    wr_en = 1'b1; wr_rd = AW'(7); wr_data = 32'h77;
    settle();
    check("sb_c4_rb", 64'(rbusy[1]), 64'd0);
    cyc();
    check("sb_c5_cnt", 64'(busy_cnt), 64'd0);
    idle();

    // Same-register issue and writeback: set wins, data still lands
    set_rs(1, 9); dbg_sel = AW'(9);
    iss_en = 1'b1; iss_rd = AW'(9);
    cyc();
    wr_en = 1'b1; wr_rd = AW'(9); wr_data = 32'hA5A5A5A5;
    settle();
    check("same_byp", 64'(rv_of(1)), 64'hA5A5A5A5);
    check("same_rb", 64'(rbusy[1]), 64'd1);
    cyc();
    check("same_cnt", 64'(busy_cnt), 64'd1);
    check("same_dbg", 64'(dbg_val), 64'hA5A5A5A5);
    idle();
    settle();
    check("same_rf", 64'(rv_of(1)), 64'hA5A5A5A5);
    check("same_rb2", 64'(rbusy[1]), 64'd1);
    wr_en = 1'b1; wr_rd = AW'(9); wr_data = 32'h99;
    cyc();
    idle();

    // Different-register issue and retire: count unchanged
    iss_en = 1'b1; iss_rd = AW'(4);
    cyc();
    check("diff_cnt0", 64'(busy_cnt), 64'd1);
    iss_rd = AW'(3); wr_en = 1'b1; wr_rd = AW'(4); wr_data = 32'h44;
    cyc();
    check("diff_cnt1", 64'(busy_cnt), 64'd1);
    idle();
    wr_en = 1'b1; wr_rd = AW'(3); wr_data = 32'h33;
    cyc();
    idle();

    // Multi-port: rs = {5,5,0} with register 5 busy
    iss_en = 1'b1; iss_rd = AW'(5);
    cyc();
    idle();
    set_rs(0, 0); set_rs(1, 5); set_rs(2, 5);
    settle();
    check("mp_rv0", 64'(rv_of(0)), 64'd0);
    check("mp_rv1", 64'(rv_of(1)), 64'hDEADBEEF);
    check("mp_rv2", 64'(rv_of(2)), 64'hDEADBEEF);
    check("mp_rb", 64'(rbusy), 64'b110);
    cyc();
    wr_en = 1'b1; wr_rd = AW'(5); wr_data = 32'h55;
    settle();
    check("mp_rv1w", 64'(rv_of(1)), 64'h55);
    check("mp_rv2w", 64'(rv_of(2)), 64'h55);
    check("mp_rbw", 64'(rbusy), 64'b000);
    cyc();
    idle();

    // Reset mid-operation with an in-flight writeback
    for (int r = 10; r <= 12; r++) begin
      iss_en = 1'b1; iss_rd = AW'(r);
      cyc();
    end
    idle();
    check("mr_cnt3", 64'(busy_cnt), 64'd3);
    rstn = 1'b0; dbg_sel = AW'(3);
    wr_en = 1'b1; wr_rd = AW'(3); wr_data = 32'hFFFF;
    cyc();
    rstn = 1'b1;
    idle();
    check("mr_cnt", 64'(busy_cnt), 64'd0);
    check("mr_dbg", 64'(dbg_val), 64'd0);
    set_rs(0, 3); set_rs(1, 10);
    settle();
    check("mr_rv", 64'(rv_of(0)), 64'(RV));
    check("mr_rb", 64'(rbusy[1]), 64'd0);
    cyc();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rstn    = ($urandom_range(0, 59) != 0);
      iss_en  = $urandom_range(0, 1) == 1;
      iss_rd  = AW'($urandom_range(0, NREGS - 1));
      wr_en   = $urandom_range(0, 1) == 1;
      wr_rd   = ($urandom_range(0, 2) == 0) ? iss_rd : AW'($urandom_range(0, NREGS - 1));
      wr_data = $urandom;
      dbg_sel = AW'($urandom_range(0, NREGS - 1));
      for (int k = 0; k < NREAD; k++) begin
        set_rs(k, ($urandom_range(0, 2) == 0) ? int'(wr_rd) : $urandom_range(0, NREGS - 1));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
